// File: rtl/gold_nic.sv
// Processor-side NIC for the ring router PE port: a one-deep rx buffer and a one-deep tx buffer
// behind a four-register load/store window.
module gold_nic (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic [63:0] d_in,
  output logic [63:0] d_out,
  input  logic        nicEn,
  input  logic        nicWrEn,
  output logic        net_so,
  input  logic        net_ri,
  output logic [63:0] net_do,
  input  logic        net_si,
  output logic        net_ro,
  input  logic [63:0] net_di,
  input  logic        net_polarity
);

  logic        rx_full_q, rx_full_d;
  logic [63:0] rx_buf_q, rx_buf_d;
  logic        tx_full_q, tx_full_d;
  logic [63:0] tx_buf_q, tx_buf_d;
  logic [63:0] d_out_q, d_out_d;

  logic tx_go, rx_acc, rd, wr_tx;

  always_comb begin
    // Bit 63 picks the VC; it may only leave on the matching polarity cycle.
    tx_go  = tx_full_q & net_ri & (net_polarity == tx_buf_q[63]);
    net_so = tx_go;
    net_do = tx_go ? tx_buf_q : 64'h0;
    net_ro = reset & ~rx_full_q;
    rx_acc = net_si & net_ro;
    rd     = nicEn & ~nicWrEn;
    // A write while full, including one at the edge the buffer leaves, is dropped.
    wr_tx  = nicEn & nicWrEn & (addr == 2'b10) & ~tx_full_q;
  end

  always_comb begin
    rx_full_d = rx_full_q;
    rx_buf_d  = rx_buf_q;
    tx_full_d = tx_full_q;
    tx_buf_d  = tx_buf_q;
    d_out_d   = d_out_q;

    if (rd) begin
      unique case (addr)
        2'b00: begin
          d_out_d = rx_buf_q;
          if (rx_full_q) rx_full_d = 1'b0;
        end
        2'b01: d_out_d = {63'b0, rx_full_q};
        2'b10: d_out_d = tx_buf_q;
        2'b11: d_out_d = {63'b0, tx_full_q};
      endcase
    end

    // net_ro is low whenever rx_full is set, so accept and read-clear never collide.
    if (rx_acc) begin
      rx_buf_d  = net_di;
      rx_full_d = 1'b1;
    end

    if (tx_go) tx_full_d = 1'b0;
    if (wr_tx) begin
      tx_buf_d  = d_in;
      tx_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_full_q <= 1'b0;
      rx_buf_q  <= 64'h0;
      tx_full_q <= 1'b0;
      tx_buf_q  <= 64'h0;
      d_out_q   <= 64'h0;
    end else begin
      rx_full_q <= rx_full_d;
      rx_buf_q  <= rx_buf_d;
      tx_full_q <= tx_full_d;
      tx_buf_q  <= tx_buf_d;
      d_out_q   <= d_out_d;
    end
  end

  assign d_out = d_out_q;

endmodule

// File: tb/tb_gold_nic.sv
// Bench for gold_nic: directed vector table, reset sequences, then random traffic
// checked against a queue-based model.
module tb_gold_nic;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic [63:0] d_in, d_out;
  logic        nicEn, nicWrEn;
  logic        net_so, net_ri, net_si, net_ro, net_polarity;
  logic [63:0] net_do, net_di;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gold_nic dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .d_in         (d_in),
    .d_out        (d_out),
    .nicEn        (nicEn),
    .nicWrEn      (nicWrEn),
    .net_so       (net_so),
    .net_ri       (net_ri),
    .net_do       (net_do),
    .net_si       (net_si),
    .net_ro       (net_ro),
    .net_di       (net_di),
    .net_polarity (net_polarity)
  );

  typedef struct {
    logic        en;
    logic        wr;
    logic [1:0]  addr;
    logic [63:0] din;
    logic        ri;
    logic        si;
    logic [63:0] di;
    logic        so;
    logic [63:0] exp_do;
    logic        ro;
    logic [63:0] dout;
  } vec_t;

  vec_t tbl[$];

  localparam logic [63:0] TxA = 64'h8000_0000_0000_00AA;
  localparam logic [63:0] RxD = 64'h1234_5678_9ABC_DEF0;
  localparam logic [63:0] P1  = 64'hAAAA_0000_0000_0001;
  localparam logic [63:0] P2  = 64'h5555_0000_0000_0002;

  task automatic add(input logic en, input logic wr, input logic [1:0] a, input logic [63:0] din,
                     input logic ri, input logic si, input logic [63:0] di, input logic so,
                     input logic [63:0] edo, input logic ro, input logic [63:0] dout);
    vec_t v;
    v.en = en; v.wr = wr; v.addr = a; v.din = din; v.ri = ri; v.si = si; v.di = di;
    v.so = so; v.exp_do = edo; v.ro = ro; v.dout = dout;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic en, input logic wr, input logic [1:0] a, input logic [63:0] din,
                       input logic ri, input logic si, input logic [63:0] di);
    nicEn = en; nicWrEn = wr; addr = a; d_in = din; net_ri = ri; net_si = si; net_di = di;
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
    net_polarity = ~net_polarity;
  endtask

  // Queue-based model: occupancy is the queue length, stale register values kept separately.
  logic [63:0] rx_q[$];
  logic [63:0] tx_q[$];
  logic [63:0] last_rx, last_tx, dout_m;

  initial begin
    logic        e_so, e_ro, was_full;
    logic [63:0] e_do;
    logic        en, wr, ri, si;
    logic [1:0]  a;
    logic [63:0] din, di;

    reset = 1'b0;
    net_polarity = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 64'h0, 1'b1, 1'b0, 64'h0);

    // Reset held for two edges
    edge_step();
    edge_step();
    #1;
    chk("reset_so", {63'b0, net_so}, 64'h0);
    chk("reset_ro", {63'b0, net_ro}, 64'h0);
    chk("reset_dout", d_out, 64'h0);
    chk("reset_do", net_do, 64'h0);
    reset = 1'b1;
    #1;
    chk("release_ro", {63'b0, net_ro}, 64'h1);
    @(posedge clk);
    #1;

    // Tx with polarity wait
    add(1, 1, 2, TxA, 1, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 1, 0, 0, 1, TxA, 1, 0);
    add(1, 0, 3, 0, 1, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
    // Tx back-pressure
    add(1, 1, 2, 64'h55, 0, 0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 4; k++) add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    add(1, 0, 3, 0, 0, 0, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 1, 0, 0, 1, 64'h55, 1, 1);
    add(1, 0, 3, 0, 1, 0, 0, 0, 0, 1, 0);
    // Overwrite while full is dropped
    add(1, 1, 2, 64'h1, 0, 0, 0, 0, 0, 1, 0);
    add(1, 1, 2, 64'h2, 0, 0, 0, 0, 0, 1, 0);
    add(1, 0, 2, 0, 0, 0, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 1, 0, 0, 1, 64'h1, 1, 1);
    // Write at the edge the buffer is sent is dropped
    add(1, 1, 2, 64'h3, 0, 0, 0, 0, 0, 1, 1);
    add(1, 1, 2, 64'h4, 1, 0, 0, 1, 64'h3, 1, 1);
    add(1, 0, 3, 0, 1, 0, 0, 0, 0, 1, 0);
    add(1, 0, 2, 0, 1, 0, 0, 0, 0, 1, 64'h3);
    // Rx path
    add(0, 0, 0, 0, 1, 1, RxD, 0, 0, 1, 64'h3);
    add(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, RxD);
    add(1, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0);
    // Rx hold-off
    add(0, 0, 0, 0, 1, 1, P1, 0, 0, 1, 0);
    add(1, 0, 1, 0, 1, 1, P2, 0, 0, 0, 1);
    add(1, 0, 0, 0, 1, 1, P2, 0, 0, 0, P1);
    add(0, 0, 0, 0, 1, 1, P2, 0, 0, 1, P1);
    add(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, P2);
    add(1, 0, 0, 0, 1, 0, 0, 0, 0, 1, P2);
    add(1, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0);

    foreach (tbl[i]) begin
      net_polarity = (i % 2 == 0);
      drive(tbl[i].en, tbl[i].wr, tbl[i].addr, tbl[i].din, tbl[i].ri, tbl[i].si, tbl[i].di);
      #2;
      chk($sformatf("vec%0d_so", i), {63'b0, net_so}, {63'b0, tbl[i].so});
      chk($sformatf("vec%0d_do", i), net_do, tbl[i].exp_do);
      chk($sformatf("vec%0d_ro", i), {63'b0, net_ro}, {63'b0, tbl[i].ro});
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_dout", i), d_out, tbl[i].dout);
    end

    // Reset mid-transfer drops a pending tx and a held rx packet
    drive(1, 1, 2'b10, 64'hC, 1'b0, 1'b0, 64'h0);
    edge_step();
    drive(0, 0, 2'b00, 64'h0, 1'b0, 1'b1, 64'hE);
    edge_step();
    drive(0, 0, 2'b00, 64'h0, 1'b1, 1'b0, 64'h0);
    reset = 1'b0;
    edge_step();
    chk("midrst_ro", {63'b0, net_ro}, 64'h0);
    chk("midrst_so", {63'b0, net_so}, 64'h0);
    chk("midrst_dout", d_out, 64'h0);
    reset = 1'b1;
    #1;
    chk("midrst_so2", {63'b0, net_so}, 64'h0);
    chk("midrst_ro2", {63'b0, net_ro}, 64'h1);
    drive(1, 0, 2'b11, 64'h0, 1'b1, 1'b0, 64'h0);
    edge_step();
    chk("midrst_txst", d_out, 64'h0);
    drive(1, 0, 2'b01, 64'h0, 1'b1, 1'b0, 64'h0);
    edge_step();
    chk("midrst_rxst", d_out, 64'h0);
    drive(1, 0, 2'b10, 64'h0, 1'b1, 1'b0, 64'h0);
    edge_step();
    chk("midrst_txbuf", d_out, 64'h0);
    drive(1, 0, 2'b00, 64'h0, 1'b1, 1'b0, 64'h0);
    edge_step();
    chk("midrst_rxbuf", d_out, 64'h0);

    // Random traffic against the model
    last_rx = 64'h0;
    last_tx = 64'h0;
    dout_m  = 64'h0;
    for (int c = 0; c < 400; c++) begin
      en  = 1'($urandom_range(0, 1));
      wr  = 1'($urandom_range(0, 1));
      a   = 2'($urandom_range(0, 3));
      din = {$urandom, $urandom};
      ri  = ($urandom_range(0, 3) != 0);
      si  = 1'($urandom_range(0, 1));
      di  = {$urandom, $urandom};
      drive(en, wr, a, din, ri, si, di);
      #2;
      e_so = (tx_q.size() != 0) && ri && (net_polarity == tx_q[0][63]);
      e_do = e_so ? tx_q[0] : 64'h0;
      e_ro = (rx_q.size() == 0);
      chk($sformatf("rnd%0d_so", c), {63'b0, net_so}, {63'b0, e_so});
      chk($sformatf("rnd%0d_do", c), net_do, e_do);
      chk($sformatf("rnd%0d_ro", c), {63'b0, net_ro}, {63'b0, e_ro});

      if (en && !wr) begin
        case (a)
          2'd0: begin
            dout_m = last_rx;
            if (rx_q.size() != 0) void'(rx_q.pop_front());
          end
          2'd1: dout_m = {63'b0, (rx_q.size() != 0)};
          2'd2: dout_m = last_tx;
          default: dout_m = {63'b0, (tx_q.size() != 0)};
        endcase
      end
      if (si && e_ro) begin
        rx_q.push_back(di);
        last_rx = di;
      end
      was_full = (tx_q.size() != 0);
      if (e_so) void'(tx_q.pop_front());
      if (en && wr && a == 2'd2 && !was_full) begin
        tx_q.push_back(din);
        last_tx = din;
      end

      edge_step();
      chk($sformatf("rnd%0d_dout", c), d_out, dout_m);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
